div_req_ctrl: RTL and testbench

DIV_REQ_CTRL -- requirements
Module: div_req_ctrl

---
 rtl/div_pkg.sv | 18 +
 rtl/div_cond_neg.sv | 14 +
 rtl/div_req_ctrl.sv | 134 +++++++++++++
 tb/tb_div_req_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider request controller: default width,
// FSM state encoding and the special operand patterns at the default width.
package div_pkg;

    localparam int DIV_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } divState_e;

    // Most negative two's-complement value and all-ones (-1) at the default width
    localparam logic [DIV_WIDTH-1:0] DIV_MIN  = {1'b1, {(DIV_WIDTH-1){1'b0}}};
    localparam logic [DIV_WIDTH-1:0] DIV_ONES = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/div_cond_neg.sv
// Combinational conditional two's-complement negate: y = neg ? -a : a (mod 2^WIDTH).
module div_cond_neg
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = neg_i ? (~a_i + WIDTH'(1)) : a_i;

endmodule

// File: rtl/div_req_ctrl.sv
// Request/response wrapper around an unsigned divider: feeds operand magnitudes,
// restores result signs, and short-circuits divide-by-zero and signed overflow.
module div_req_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    input  logic             req_signed,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_div_zero,
    output logic             rsp_overflow
);

    localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};

    divState_e        state_q;
    logic             reqReady_q;
    logic             rspValid_q;
    logic             qNeg_q;
    logic             rNeg_q;
    logic [WIDTH-1:0] divDividend_q;
    logic [WIDTH-1:0] divDivisor_q;
    logic [WIDTH-1:0] rspQuot_q;
    logic [WIDTH-1:0] rspRem_q;
    logic             divZero_q;
    logic             overflow_q;

    logic             aNeg;
    logic             bNeg;
    logic             isZero;
    logic             isOvf;
    logic [WIDTH-1:0] dividendMag;
    logic [WIDTH-1:0] divisorMag;
    logic [WIDTH-1:0] quotFix;
    logic [WIDTH-1:0] remFix;

    assign aNeg   = req_signed & req_dividend[WIDTH-1];
    assign bNeg   = req_signed & req_divisor[WIDTH-1];
    assign isZero = (req_divisor == '0);
    assign isOvf  = req_signed && (req_dividend == MinVal) && (req_divisor == AllOnes);

    div_cond_neg #(.WIDTH(WIDTH)) uNegDividend (.a_i(req_dividend), .neg_i(aNeg),   .y_o(dividendMag));
    div_cond_neg #(.WIDTH(WIDTH)) uNegDivisor  (.a_i(req_divisor),  .neg_i(bNeg),   .y_o(divisorMag));
    div_cond_neg #(.WIDTH(WIDTH)) uNegQuot     (.a_i(div_quotient), .neg_i(qNeg_q), .y_o(quotFix));
    div_cond_neg #(.WIDTH(WIDTH)) uNegRem      (.a_i(div_remainder),.neg_i(rNeg_q), .y_o(remFix));

    // Divider operands stay frozen from accept until the response is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            reqReady_q    <= 1'b1;
            rspValid_q    <= 1'b0;
            qNeg_q        <= 1'b0;
            rNeg_q        <= 1'b0;
            divDividend_q <= '0;
            divDivisor_q  <= '0;
            rspQuot_q     <= '0;
            rspRem_q      <= '0;
            divZero_q     <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        reqReady_q    <= 1'b0;
                        divDividend_q <= dividendMag;
                        divDivisor_q  <= divisorMag;
                        qNeg_q        <= aNeg ^ bNeg;
                        rNeg_q        <= aNeg;
                        if (isZero) begin
                            rspQuot_q  <= AllOnes;
                            rspRem_q   <= req_dividend;
                            divZero_q  <= 1'b1;
                            overflow_q <= 1'b0;
                            rspValid_q <= 1'b1;
                            state_q    <= DONE;
                        end else if (isOvf) begin
                            rspQuot_q  <= req_dividend;
                            rspRem_q   <= '0;
                            divZero_q  <= 1'b0;
                            overflow_q <= 1'b1;
                            rspValid_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            divZero_q  <= 1'b0;
                            overflow_q <= 1'b0;
                            state_q    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    rspQuot_q  <= quotFix;
                    rspRem_q   <= remFix;
                    rspValid_q <= 1'b1;
                    state_q    <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        reqReady_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready     = reqReady_q;
    assign rsp_valid     = rspValid_q;
    assign div_dividend  = divDividend_q;
    assign div_divisor   = divDivisor_q;
    assign rsp_quotient  = rspQuot_q;
    assign rsp_remainder = rspRem_q;
    assign rsp_div_zero  = divZero_q;
    assign rsp_overflow  = overflow_q;

endmodule

// File: tb/tb_div_req_ctrl.sv
// Directed bench for div_req_ctrl with a behavioural one-cycle divider attached
// at this level, exactly as the controller would see it in the parent.
module tb_div_req_ctrl;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_dividend;
    logic [63:0] req_divisor;
    logic        req_signed;
    logic [63:0] div_dividend;
    logic [63:0] div_divisor;
    logic [63:0] div_quotient;
    logic [63:0] div_remainder;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_quotient;
    logic [63:0] rsp_remainder;
    logic        rsp_div_zero;
    logic        rsp_overflow;

    int errors = 0;
    int checks = 0;

    div_req_ctrl #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor), .req_signed(req_signed),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_div_zero(rsp_div_zero), .rsp_overflow(rsp_overflow)
    );

    always #5 clk = ~clk;

    // Unsigned divider with registered outputs (one edge of latency)
    always @(posedge clk) begin
        if (div_divisor != 64'd0) begin
            div_quotient  <= div_dividend / div_divisor;
            div_remainder <= div_dividend % div_divisor;
        end else begin
            div_quotient  <= DIV_ONES;
            div_remainder <= div_dividend;
        end
    end

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [63:0] a, input logic [63:0] b, input logic s);
        req_dividend = a;
        req_divisor  = b;
        req_signed   = s;
        req_valid    = 1'b1;
        waitEdges(1);
        req_valid    = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        waitEdges(1);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if ({rsp_div_zero, rsp_overflow} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {rsp_div_zero, rsp_overflow}); end
        checks++; if ({rsp_quotient, rsp_remainder} !== 128'd0) begin errors++; $display("[TB] FAIL reset_rsp_data: got %h %h expected 0 0", rsp_quotient, rsp_remainder); end
        checks++; if ({div_dividend, div_divisor} !== 128'd0) begin errors++; $display("[TB] FAIL reset_div_ops: got %h %h expected 0 0", div_dividend, div_divisor); end
    endtask

    task automatic test_unsigned();
        present(64'd87, 64'd5, 1'b0);
        checks++; if (div_dividend !== 64'd87 || div_divisor !== 64'd5) begin errors++; $display("[TB] FAIL u87_ops: got %0d %0d expected 87 5", div_dividend, div_divisor); end
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("[TB] FAIL u87_edge1: got valid=%b ready=%b expected 0 0", rsp_valid, req_ready); end
        waitEdges(1);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL u87_edge2: got %b expected 0", rsp_valid); end
        waitEdges(1);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL u87_edge3: got %b expected 1", rsp_valid); end
        checks++; if (rsp_quotient !== 64'd17 || rsp_remainder !== 64'd2) begin errors++; $display("[TB] FAIL u87_result: got %0d %0d expected 17 2", rsp_quotient, rsp_remainder); end
        checks++; if ({rsp_div_zero, rsp_overflow} !== 2'b00) begin errors++; $display("[TB] FAIL u87_flags: got %b expected 00", {rsp_div_zero, rsp_overflow}); end
        handshake();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL u87_release: got valid=%b ready=%b expected 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_signed();
        present(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
        checks++; if (div_dividend !== 64'd7 || div_divisor !== 64'd2) begin errors++; $display("[TB] FAIL sneg7_ops: got %h %h expected 7 2", div_dividend, div_divisor); end
        waitEdges(2);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL sneg7_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_quotient !== 64'hFFFF_FFFF_FFFF_FFFD || rsp_remainder !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL sneg7_result: got %h %h expected fffffffffffffffd ffffffffffffffff", rsp_quotient, rsp_remainder); end
        handshake();
        present(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        checks++; if (div_divisor !== 64'd2) begin errors++; $display("[TB] FAIL s7negdiv_op: got %h expected 2", div_divisor); end
        waitEdges(2);
        checks++; if (rsp_quotient !== 64'hFFFF_FFFF_FFFF_FFFD || rsp_remainder !== 64'd1) begin errors++; $display("[TB] FAIL s7negdiv_result: got %h %h expected fffffffffffffffd 1", rsp_quotient, rsp_remainder); end
        handshake();
    endtask

    task automatic test_div_zero();
        present(64'd59, 64'd0, 1'b0);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL dz_valid: got %b expected 1", rsp_valid); end
        checks++; if ({rsp_div_zero, rsp_overflow} !== 2'b10) begin errors++; $display("[TB] FAIL dz_flags: got %b expected 10", {rsp_div_zero, rsp_overflow}); end
        checks++; if (rsp_quotient !== DIV_ONES || rsp_remainder !== 64'd59) begin errors++; $display("[TB] FAIL dz_result: got %h %0d expected ffffffffffffffff 59", rsp_quotient, rsp_remainder); end
        handshake();
    endtask

    task automatic test_overflow();
        present(DIV_MIN, DIV_ONES, 1'b1);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_valid: got %b expected 1", rsp_valid); end
        checks++; if ({rsp_div_zero, rsp_overflow} !== 2'b01) begin errors++; $display("[TB] FAIL ovf_flags: got %b expected 01", {rsp_div_zero, rsp_overflow}); end
        checks++; if (rsp_quotient !== DIV_MIN || rsp_remainder !== 64'd0) begin errors++; $display("[TB] FAIL ovf_result: got %h %h expected 8000000000000000 0", rsp_quotient, rsp_remainder); end
        handshake();
        // Same bit patterns unsigned are an ordinary division
        present(DIV_MIN, DIV_ONES, 1'b0);
        checks++; if (rsp_valid !== 1'b0 || div_divisor !== DIV_ONES) begin errors++; $display("[TB] FAIL umin_issue: got valid=%b divisor=%h expected 0 ffffffffffffffff", rsp_valid, div_divisor); end
        waitEdges(2);
        checks++; if (rsp_valid !== 1'b1 || {rsp_div_zero, rsp_overflow} !== 2'b00) begin errors++; $display("[TB] FAIL umin_done: got valid=%b flags=%b expected 1 00", rsp_valid, {rsp_div_zero, rsp_overflow}); end
        checks++; if (rsp_quotient !== 64'd0 || rsp_remainder !== DIV_MIN) begin errors++; $display("[TB] FAIL umin_result: got %h %h expected 0 8000000000000000", rsp_quotient, rsp_remainder); end
        handshake();
    endtask

    task automatic test_back_to_back();
        present(DIV_ONES, 64'd2, 1'b0);
        waitEdges(2);
        checks++; if (rsp_valid !== 1'b1 || rsp_quotient !== 64'h7FFF_FFFF_FFFF_FFFF || rsp_remainder !== 64'd1) begin errors++; $display("[TB] FAIL bp_result: got valid=%b %h %h expected 1 7fffffffffffffff 1", rsp_valid, rsp_quotient, rsp_remainder); end
        req_dividend = 64'd100;
        req_divisor  = 64'd7;
        req_signed   = 1'b0;
        req_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            waitEdges(1);
            checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_quotient !== 64'h7FFF_FFFF_FFFF_FFFF || rsp_remainder !== 64'd1) begin errors++; $display("[TB] FAIL bp_hold%0d: got valid=%b ready=%b %h %h expected 1 0 7fffffffffffffff 1", i, rsp_valid, req_ready, rsp_quotient, rsp_remainder); end
        end
        handshake();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || div_dividend !== DIV_ONES) begin errors++; $display("[TB] FAIL bp_release: got valid=%b ready=%b dividend=%h expected 0 1 ffffffffffffffff", rsp_valid, req_ready, div_dividend); end
        waitEdges(1);
        req_valid = 1'b0;
        checks++; if (div_dividend !== 64'd100 || req_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept: got dividend=%0d ready=%b expected 100 0", div_dividend, req_ready); end
        waitEdges(2);
        checks++; if (rsp_valid !== 1'b1 || rsp_quotient !== 64'd14 || rsp_remainder !== 64'd2) begin errors++; $display("[TB] FAIL b2b_result: got valid=%b %0d %0d expected 1 14 2", rsp_valid, rsp_quotient, rsp_remainder); end
        handshake();
    endtask

    task automatic test_reset_in_wait();
        present(64'd100, 64'd9, 1'b0);
        waitEdges(1);
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || {rsp_div_zero, rsp_overflow} !== 2'b00) begin errors++; $display("[TB] FAIL rstw_ctrl: got ready=%b valid=%b flags=%b expected 1 0 00", req_ready, rsp_valid, {rsp_div_zero, rsp_overflow}); end
        checks++; if ({rsp_quotient, rsp_remainder, div_dividend, div_divisor} !== 256'd0) begin errors++; $display("[TB] FAIL rstw_data: got %h %h %h %h expected all 0", rsp_quotient, rsp_remainder, div_dividend, div_divisor); end
        waitEdges(1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            waitEdges(1);
            checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstw_idle%0d: got valid=%b ready=%b expected 0 1", i, rsp_valid, req_ready); end
        end
        present(64'd20, 64'd3, 1'b0);
        waitEdges(2);
        checks++; if (rsp_valid !== 1'b1 || rsp_quotient !== 64'd6 || rsp_remainder !== 64'd2) begin errors++; $display("[TB] FAIL rstw_next: got valid=%b %0d %0d expected 1 6 2", rsp_valid, rsp_quotient, rsp_remainder); end
        handshake();
    endtask

    initial begin
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_dividend = '0;
        req_divisor  = '0;
        req_signed   = 1'b0;
        rsp_ready    = 1'b0;
        #12;
        test_reset();
        reset = 1'b1;
        waitEdges(1);
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
